// File: rtl/micro_sequencer_pkg.sv
// micro_sequencer_pkg: shared control-unit encodings for the microstore next-address fields.
package micro_sequencer_pkg;

    typedef logic [5:0] state_t;

    typedef enum logic [2:0] {
        NS_DECODE = 3'd0,
        NS_FETCH  = 3'd1,
        NS_INCR   = 3'd2,
        NS_JUMP   = 3'd3,
        NS_CJUMP  = 3'd4,
        NS_CALL   = 3'd5,
        NS_RETURN = 3'd6,
        NS_WAIT   = 3'd7
    } ns_sel_e;

    typedef enum logic [1:0] {
        COND_MOC  = 2'd0,
        COND_TRUE = 2'd1,
        COND_ONE  = 2'd2,
        COND_ZERO = 2'd3
    } cond_sel_e;

    localparam logic [1:0] FC_NONE      = 2'b00;
    localparam logic [1:0] FC_TIMEOUT   = 2'b01;
    localparam logic [1:0] FC_UNDERFLOW = 2'b10;
    localparam logic [1:0] FC_OVERFLOW  = 2'b11;

endpackage

// File: rtl/micro_next_addr_mux.sv
// micro_next_addr_mux: combinational next microstore index selection with fault override.
module micro_next_addr_mux
    import micro_sequencer_pkg::*;
#(
    parameter state_t RESET_STATE = 6'd0,
    parameter state_t FAULT_STATE = 6'd63,
    parameter int     MOC_TIMEOUT = 16
) (
    input  state_t     state_i,
    input  logic [2:0] ns_sel_i,
    input  logic [1:0] cond_sel_i,
    input  logic       inv_i,
    input  state_t     cr_addr_i,
    input  state_t     encoder_state_i,
    input  logic       moc_i,
    input  logic       cond_true_i,
    input  state_t     ret_reg_i,
    input  logic       ret_valid_i,
    input  logic [7:0] wait_cnt_i,
    output state_t     next_state_o,
    output state_t     inc_o,
    output logic       fault_o,
    output logic [1:0] fault_code_o,
    output logic       ret_load_o,
    output logic       ret_clear_o,
    output logic       wait_inc_o
);

    ns_sel_e   ns;
    cond_sel_e cs;
    logic      c, timeout, underflow, overflow;
    state_t    sel_addr;

    assign ns    = ns_sel_e'(ns_sel_i);
    assign cs    = cond_sel_e'(cond_sel_i);
    assign c     = inv_i ^ (cs == COND_MOC  ? moc_i :
                            cs == COND_TRUE ? cond_true_i :
                            cs == COND_ONE);
    assign inc_o = state_i + 6'd1;

    // Counter compared before increment, so the loop holds MOC_TIMEOUT cycles before faulting.
    assign timeout   = ns == NS_WAIT && !c && wait_cnt_i == 8'(MOC_TIMEOUT);
    assign underflow = ns == NS_RETURN && !ret_valid_i;
    assign overflow  = ns == NS_CALL && ret_valid_i;
    assign fault_o   = timeout | underflow | overflow;
    assign fault_code_o = timeout   ? FC_TIMEOUT :
                          underflow ? FC_UNDERFLOW :
                          overflow  ? FC_OVERFLOW : FC_NONE;

    always_comb begin
        sel_addr = inc_o;
        case (ns)
            NS_DECODE: sel_addr = encoder_state_i;
            NS_FETCH:  sel_addr = RESET_STATE;
            NS_INCR:   sel_addr = inc_o;
            NS_JUMP:   sel_addr = cr_addr_i;
            NS_CJUMP:  sel_addr = c ? cr_addr_i : inc_o;
            NS_CALL:   sel_addr = cr_addr_i;
            NS_RETURN: sel_addr = ret_reg_i;
            NS_WAIT:   sel_addr = c ? inc_o : state_i;
        endcase
    end

    assign next_state_o = fault_o ? FAULT_STATE : sel_addr;
    assign ret_load_o   = ns == NS_CALL && !fault_o;
    assign ret_clear_o  = ns == NS_RETURN && !fault_o;
    assign wait_inc_o   = ns == NS_WAIT && !c && !fault_o;

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: registered microstore index with one-level return register,
// memory-wait timeout and sticky first-fault reporting.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter state_t RESET_STATE = 6'd0,
    parameter state_t FAULT_STATE = 6'd63,
    parameter int     MOC_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic [2:0] ns_sel,
    input  logic [1:0] cond_sel,
    input  logic       inv,
    input  logic [5:0] cr_addr,
    input  logic [5:0] encoder_state,
    input  logic       moc,
    input  logic       cond_true,
    output logic [5:0] state,
    output logic       ret_valid,
    output logic       fault,
    output logic [1:0] fault_code
);

    state_t     state_q, ret_q, next_d, inc_d;
    logic       ret_valid_q, fault_q, hit_d, ret_load_d, ret_clear_d, wait_inc_d;
    logic [1:0] code_q, code_d;
    logic [7:0] wait_q;

    micro_next_addr_mux #(
        .RESET_STATE(RESET_STATE),
        .FAULT_STATE(FAULT_STATE),
        .MOC_TIMEOUT(MOC_TIMEOUT)
    ) u_mux (
        .state_i        (state_q),
        .ns_sel_i       (ns_sel),
        .cond_sel_i     (cond_sel),
        .inv_i          (inv),
        .cr_addr_i      (cr_addr),
        .encoder_state_i(encoder_state),
        .moc_i          (moc),
        .cond_true_i    (cond_true),
        .ret_reg_i      (ret_q),
        .ret_valid_i    (ret_valid_q),
        .wait_cnt_i     (wait_q),
        .next_state_o   (next_d),
        .inc_o          (inc_d),
        .fault_o        (hit_d),
        .fault_code_o   (code_d),
        .ret_load_o     (ret_load_d),
        .ret_clear_o    (ret_clear_d),
        .wait_inc_o     (wait_inc_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            ret_q       <= '0;
            ret_valid_q <= 1'b0;
            wait_q      <= '0;
            fault_q     <= 1'b0;
            code_q      <= FC_NONE;
        end else if (!stall) begin
            state_q     <= next_d;
            ret_q       <= ret_load_d ? inc_d : ret_q;
            ret_valid_q <= ret_load_d | (ret_valid_q & ~ret_clear_d);
            wait_q      <= wait_inc_d ? wait_q + 8'd1 : 8'd0;
            fault_q     <= fault_q | hit_d;
            code_q      <= (hit_d && !fault_q) ? code_d : code_q;
        end
    end

    assign state      = state_q;
    assign ret_valid  = ret_valid_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule
